fixed_point_mult_pipe: RTL

//  Pipelined, parametrised fixed-point multiplier for the FFT butterfly datapath (twiddle x sample).

---
 rtl/fixed_point_mult_pipe.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/fixed_point_mult_pipe.sv
// fixed_point_mult_pipe
// Three-stage pipelined Q(INT_BITS).(FRAC_BITS) multiplier for the FFT
// butterfly datapath. Operands are sign-magnitude (SIGN_MAG=1) or two's
// complement (SIGN_MAG=0). Products are rounded and range-checked.
// A single global advance provides full valid/ready backpressure.
// Build option: define FIXED_POINT_SAT_EN to saturate on overflow. Without it,
// an overflowing product wraps to its low bits. The overflow flag is raised
// the same way in both builds.
module fixed_point_mult_pipe #(
   parameter int INT_BITS  = 8,
   parameter int FRAC_BITS = 8,
   parameter bit SIGN_MAG  = 1'b1,
   localparam int W        = INT_BITS + FRAC_BITS
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] input1,
   input  logic [W-1:0] input2,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] product,
   output logic         overflow
);

   localparam int PW = 2 * W;   // full product width
   localparam int RW = PW + 1;  // headroom for the rounding bias

`ifdef FIXED_POINT_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   // Rounding bias is half an LSB of the result.
   localparam logic signed [RW-1:0] HALF    = {{(RW-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);
   // Largest positive and most negative representable results, sign-extended to RW bits.
   localparam logic signed [RW-1:0] POS_MAX = {{(RW-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [RW-1:0] NEG_MIN = {{(RW-W+1){1'b1}}, {(W-1){1'b0}}};

   // Every stage moves together. The pipe only stalls when the output holds a product nobody takes.
   logic adv_s;
   assign adv_s    = ~out_valid | out_ready;
   assign in_ready = adv_s;

   // Stage 1 registers: decoded operands and result sign
   logic         s1_valid_r;
   logic         s1_sign_r;
   logic [W-1:0] s1_a_r;
   logic [W-1:0] s1_b_r;

   // Stage 2 registers: full-width product
   logic          s2_valid_r;
   logic          s2_sign_r;
   logic [PW-1:0] s2_prod_r;

   // Combinational intermediates
   logic [W-1:0]          a_dec_s;
   logic [W-1:0]          b_dec_s;
   logic                  sign_dec_s;
   logic signed [PW-1:0]  a_ext_s;
   logic signed [PW-1:0]  b_ext_s;
   logic signed [PW-1:0]  mul_s;
   logic signed [RW-1:0]  biased_s;
   logic signed [RW-1:0]  rounded_s;
   logic [W-2:0]          mag_s;
   logic                  sign_s;
   logic                  ovf_s;
   logic [W-1:0]          result_s;

   // Operand decode: strip sign bits in sign-magnitude mode so -0 reads as magnitude zero
   always_comb begin
      a_dec_s    = input1;
      b_dec_s    = input2;
      sign_dec_s = 1'b0;
      if (SIGN_MAG) begin
         a_dec_s    = {1'b0, input1[W-2:0]};
         b_dec_s    = {1'b0, input2[W-2:0]};
         sign_dec_s = input1[W-1] ^ input2[W-1];
      end else begin
         a_dec_s    = input1;
         b_dec_s    = input2;
         sign_dec_s = 1'b0;
      end
   end

   // One signed multiplier serves both formats; magnitudes are zero-extended so they stay positive
   always_comb begin
      a_ext_s = {PW{1'b0}};
      b_ext_s = {PW{1'b0}};
      if (SIGN_MAG) begin
         a_ext_s = $signed({{W{1'b0}}, s1_a_r});
         b_ext_s = $signed({{W{1'b0}}, s1_b_r});
      end else begin
         a_ext_s = $signed({{W{s1_a_r[W-1]}}, s1_a_r});
         b_ext_s = $signed({{W{s1_b_r[W-1]}}, s1_b_r});
      end
      mul_s = a_ext_s * b_ext_s;
   end

   // Round to FRAC_BITS, detect overflow before any clamp, then saturate or wrap
   always_comb begin
      biased_s  = $signed({s2_prod_r[PW-1], s2_prod_r}) + HALF;
      rounded_s = biased_s >>> FRAC_BITS;
      ovf_s     = 1'b0;
      mag_s     = rounded_s[W-2:0];
      sign_s    = 1'b0;
      result_s  = rounded_s[W-1:0];
      if (SIGN_MAG) begin
         // Magnitude is non-negative, so ">= 2^(W-1)" is the same as "> POS_MAX"
         ovf_s = (rounded_s > POS_MAX);
         if (ovf_s && SAT_EN) begin
            mag_s = {(W-1){1'b1}};
         end else begin
            mag_s = rounded_s[W-2:0];
         end
         // A zero magnitude is always emitted as +0
         sign_s   = (mag_s != {(W-1){1'b0}}) ? s2_sign_r : 1'b0;
         result_s = {sign_s, mag_s};
      end else begin
         ovf_s = (rounded_s > POS_MAX) || (rounded_s < NEG_MIN);
         if (ovf_s && SAT_EN) begin
            result_s = rounded_s[RW-1] ? NEG_MIN[W-1:0] : POS_MAX[W-1:0];
         end else begin
            result_s = rounded_s[W-1:0];
         end
      end
   end

   // Stage 1: capture decoded operands on accept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         s1_sign_r  <= 1'b0;
         s1_a_r     <= {W{1'b0}};
         s1_b_r     <= {W{1'b0}};
      end else if (adv_s) begin
         s1_valid_r <= in_valid;
         if (in_valid) begin
            s1_sign_r <= sign_dec_s;
            s1_a_r    <= a_dec_s;
            s1_b_r    <= b_dec_s;
         end
      end
   end

   // Stage 2: register the full-width product
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid_r <= 1'b0;
         s2_sign_r  <= 1'b0;
         s2_prod_r  <= {PW{1'b0}};
      end else if (adv_s) begin
         s2_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            s2_sign_r <= s1_sign_r;
            s2_prod_r <= mul_s;
         end
      end
   end

   // Stage 3: output register. Product and flag hold while downstream stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         product   <= {W{1'b0}};
         overflow  <= 1'b0;
      end else if (adv_s) begin
         out_valid <= s2_valid_r;
         if (s2_valid_r) begin
            product  <= result_s;
            overflow <= ovf_s;
         end
      end
   end

endmodule
